// File: rtl/word_decoder_pkg.sv
// Shared types and widths for the per-word decoder of the C-Pack-style decompressor.
package word_decoder_pkg;

    // Data word and the literal fields carried inside it
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    // Code field width and dictionary defaults
    localparam int unsigned CODE_W    = 2;
    localparam int unsigned DICT_N    = 16;
    localparam int unsigned LINE_W    = 196;
    localparam int unsigned LIT_W     = 34;

    // Primary code
    typedef enum logic [CODE_W-1:0] {
        CODE_ZERO  = 2'b00,
        CODE_LIT   = 2'b01,
        CODE_MATCH = 2'b10,
        CODE_EXT   = 2'b11
    } code_e;

    // Secondary code, meaningful only under CODE_EXT
    typedef enum logic [CODE_W-1:0] {
        BAK_HALF_LIT = 2'b00,
        BAK_BYTE_LIT = 2'b01,
        BAK_PARTIAL  = 2'b10,
        BAK_FULL_LIT = 2'b11
    } bak_e;

    // Index width that stays at least one bit for a single-entry dictionary
    function automatic int unsigned idx_width(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/word_decoder_dict_select.sv
// WORD:1 dictionary entry selector; an index with no matching entry reads zero.
module word_decoder_dict_select
    import word_decoder_pkg::*;
#(
    parameter int unsigned WORD  = DICT_N,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WORD*WIDTH-1:0]     i_dict,
    input  logic [idx_width(WORD)-1:0] i_idx,
    output logic [WIDTH-1:0]          o_entry
);

    localparam int unsigned IDX_W = idx_width(WORD);

    // Compare-and-select over every entry so out-of-range indices fall through to zero
    always_comb begin
        o_entry = '0;
        for (int k = 0; k < int'(WORD); k++) begin
            if (i_idx == IDX_W'(k)) begin
                o_entry = i_dict[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/word_decoder.sv
// Per-word decode stage: rebuilds one data word from primary/secondary codes,
// literal bits and a dictionary snapshot.
// Build option WORD_DECODER_COMB_OUT_EN: removes the output register (0-cycle latency,
// output gated to zero when i_valid is low); default is a 1-cycle registered output.
module word_decoder
    import word_decoder_pkg::*;
#(
    parameter int unsigned CODES   = CODE_W,
    parameter int unsigned WORD    = DICT_N,
    parameter int unsigned WIDTH   = DATA_W,
    parameter int unsigned I_WORD  = LINE_W,
    parameter int unsigned I_WORD2 = LIT_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic [CODES-1:0]            i_codes,
    input  logic [CODES-1:0]            i_codes_bak,
    input  logic [I_WORD2-1:0]          i_word,
    input  logic [idx_width(WORD)-1:0]  i_idx,
    input  logic [WORD*WIDTH-1:0]       i_dict,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_word
);

    logic [WIDTH-1:0] dict_word_c;
    logic [WIDTH-1:0] lit_word_c;
    logic [WIDTH-1:0] decoded_c;

    // Dictionary entry addressed by the index
    word_decoder_dict_select #(
        .WORD  (WORD),
        .WIDTH (WIDTH)
    ) u_dict_select (
        .i_dict  (i_dict),
        .i_idx   (i_idx),
        .o_entry (dict_word_c)
    );

    // Literal bits above the data word are carried upstream but never decoded
    assign lit_word_c = i_word[WIDTH-1:0];

    // Code-to-word decode; every code combination maps to a defined word
    always_comb begin
        decoded_c = '0;
        case (i_codes)
            CODE_ZERO:  decoded_c = '0;
            CODE_LIT:   decoded_c = lit_word_c;
            CODE_MATCH: decoded_c = dict_word_c;
            CODE_EXT: begin
                case (i_codes_bak)
                    BAK_HALF_LIT: decoded_c = WIDTH'(lit_word_c[HALF_W-1:0]);
                    BAK_BYTE_LIT: decoded_c = WIDTH'(lit_word_c[BYTE_W-1:0]);
                    BAK_PARTIAL:  decoded_c = {dict_word_c[WIDTH-1:BYTE_W],
                                               lit_word_c[BYTE_W-1:0]};
                    BAK_FULL_LIT: decoded_c = lit_word_c;
                    default:      decoded_c = '0;
                endcase
            end
            default:    decoded_c = '0;
        endcase
    end

`ifdef WORD_DECODER_COMB_OUT_EN

    // Combinational output, forced to zero while nothing valid is presented
    assign o_valid = i_valid;
    assign o_word  = i_valid ? decoded_c : '0;

    // Clock, reset and the unused literal/code-line widths are intentionally sunk here
    logic unused_sink;
    if (I_WORD2 > WIDTH) begin : g_hi_sink
        assign unused_sink = ^{i_clk, i_rst, i_word[I_WORD2-1:WIDTH], 32'(I_WORD)};
    end else begin : g_no_hi_sink
        assign unused_sink = ^{i_clk, i_rst, 32'(I_WORD)};
    end

`else

    // Registered output; the word holds when no valid input arrives, reset drops it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_word  <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_word <= decoded_c;
            end
        end
    end

    // Unused literal bits above the data word and the code-line width are sunk here
    logic unused_sink;
    if (I_WORD2 > WIDTH) begin : g_hi_sink
        assign unused_sink = ^{i_word[I_WORD2-1:WIDTH], 32'(I_WORD)};
    end else begin : g_no_hi_sink
        assign unused_sink = ^{32'(I_WORD)};
    end

`endif

endmodule

// File: tb/tb_word_decoder.sv
// Self-checking bench for word_decoder: directed code cases, reset behaviour and a
// randomized sweep against a behavioural decode model. Follows WORD_DECODER_COMB_OUT_EN.
module tb_word_decoder;

    localparam int unsigned N_ENT = 16;
    localparam int unsigned DW    = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  valid;
    logic [1:0]            codes;
    logic [1:0]            bak;
    logic [33:0]           word;
    logic [3:0]            idx;
    logic [N_ENT*DW-1:0]   dict_bus;
    logic                  o_valid;
    logic [DW-1:0]         o_word;

    int unsigned dict_m [N_ENT];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_word = '0;
    logic        exp_valid = 1'b0;

    word_decoder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_codes     (codes),
        .i_codes_bak (bak),
        .i_word      (word),
        .i_idx       (idx),
        .i_dict      (dict_bus),
        .o_valid     (o_valid),
        .o_word      (o_word)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Model dictionary -> packed bus
    task automatic load_dict();
        for (int k = 0; k < int'(N_ENT); k++) dict_bus[k*DW +: DW] = dict_m[k];
    endtask

    // Behavioural decode from the code table, using plain arithmetic
    function automatic logic [31:0] ref_decode(input int c, input int b,
                                               input longint unsigned w, input int i);
        longint unsigned lit = w % 64'h1_0000_0000;
        longint unsigned d   = 64'(dict_m[i]);
        case (c)
            0: return 32'h0;
            1: return 32'(lit);
            2: return 32'(d);
            default: begin
                case (b)
                    0: return 32'(lit % 65536);
                    1: return 32'(lit % 256);
                    2: return 32'((d / 256) * 256 + (lit % 256));
                    default: return 32'(lit);
                endcase
            end
        endcase
    endfunction

    // Present one input set and check the result at the correct latency
    task automatic step(input string tag, input logic v, input logic [1:0] c,
                        input logic [1:0] b, input logic [33:0] w,
                        input logic [3:0] i, input logic [31:0] e);
        @(negedge clk);
        valid = v; codes = c; bak = b; word = w; idx = i;
`ifdef WORD_DECODER_COMB_OUT_EN
        #1;
        exp_valid = v;
        exp_word  = v ? e : 32'h0;
`else
        exp_valid = v;
        if (v) exp_word = e;
        @(posedge clk);
        #1;
`endif
        check({tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
        check({tag, ".word"},  o_word, exp_word);
    endtask

    task automatic rand_sweep(input string tag, input int n);
        logic [1:0]  c, b;
        logic [3:0]  i;
        logic [33:0] w;
        logic        v;
        for (int t = 0; t < n; t++) begin
            v = ($urandom_range(0, 4) != 0);
            c = 2'($urandom);
            b = 2'($urandom);
            i = 4'($urandom);
            w = {2'($urandom), 32'($urandom)};
            step(tag, v, c, b, w, i, ref_decode(int'(c), int'(b), 64'(w), int'(i)));
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; codes = '0; bak = '0; word = '0; idx = '0;
        for (int k = 0; k < int'(N_ENT); k++) dict_m[k] = k * 100;
        load_dict();

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(o_valid), 32'h0);
        check("reset.word",  o_word, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases; literals above 32 bits are given pre-truncated to 34 bits
        step("zero",      1'b1, 2'b00, 2'b00, 34'h123456789, 4'd4, 32'h00000000);
        step("literal",   1'b1, 2'b01, 2'b00, 34'h1EADBEEF1, 4'd0, 32'hEADBEEF1);
        step("match",     1'b1, 2'b10, 2'b00, 34'h000000000, 4'd7, 32'h000002BC);
        step("half_lit",  1'b1, 2'b11, 2'b00, 34'h2BCDEF123, 4'd0, 32'h0000F123);
        step("byte_lit",  1'b1, 2'b11, 2'b01, 34'h2BCDEF123, 4'd0, 32'h00000023);
        step("partial",   1'b1, 2'b11, 2'b10, 34'h2BCDEF123, 4'd3, 32'h00000123);
        step("full_lit",  1'b1, 2'b11, 2'b11, 34'h2BCDEF123, 4'd0, 32'hBCDEF123);
        step("last_idx",  1'b1, 2'b10, 2'b01, 34'h0, 4'd15, 32'd1500);

`ifndef WORD_DECODER_COMB_OUT_EN
        // Asynchronous reset mid-stream, observed before the next rising edge
        @(negedge clk);
        valid = 1'b1; codes = 2'b01; word = 34'h0_CAFEF00D;
        #2 rst = 1'b1;
        #1;
        check("async_rst.valid", 32'(o_valid), 32'h0);
        check("async_rst.word",  o_word, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held.valid", 32'(o_valid), 32'h0);
        check("rst_held.word",  o_word, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_word = 32'h0; exp_valid = 1'b0;
`endif

        // Idle cycles: output word holds, valid drops
        step("idle_pre",  1'b1, 2'b01, 2'b00, 34'h0_13579BDF, 4'd0, 32'h13579BDF);
        step("idle1",     1'b0, 2'b10, 2'b11, 34'h3FFFFFFFF, 4'd9, 32'hFFFFFFFF);
        step("idle2",     1'b0, 2'b01, 2'b00, 34'h3FFFFFFFF, 4'd2, 32'hFFFFFFFF);

        rand_sweep("rand_k100", 200);

        // Random dictionary contents exercise the upper entry bits
        for (int k = 0; k < int'(N_ENT); k++) dict_m[k] = $urandom;
        @(negedge clk);
        load_dict();
        rand_sweep("rand_dict", 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
